// File: rtl/com_pkg.sv
// Shared definitions for the centroid engine: datapath width default, FSM
// encoding and the active video area used by stimulus generators.
package com_pkg;

  localparam int DIV_BITS_DEFAULT = 32;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

  typedef enum logic {
    IDLE,
    DIVIDING
  } state_t;

endpackage

// File: rtl/divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// resolved on the start edge, so valid_out pulses DIV_BITS cycles after start_in.
module divider
  import com_pkg::*;
#(
  parameter int DIV_BITS = DIV_BITS_DEFAULT
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic [DIV_BITS-1:0] dividend_in,
  input  logic [DIV_BITS-1:0] divisor_in,
  output logic [DIV_BITS-1:0] quotient_out,
  output logic [DIV_BITS-1:0] remainder_out,
  output logic                valid_out,
  output logic                busy_out
);

  localparam int CNT_W = $clog2(DIV_BITS + 1);

  logic [DIV_BITS-1:0] rem_q, quo_q, div_q;
  logic [CNT_W-1:0]    cnt;
  logic [DIV_BITS-1:0] src_rem, src_quo, src_div, next_rem, next_quo;
  logic [DIV_BITS:0]   shifted, diff;
  logic                fits;

  // NOTE: every output of a combinational block gets a default on entry so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    src_rem  = start_in ? '0 : rem_q;
    src_quo  = start_in ? dividend_in : quo_q;
    src_div  = start_in ? divisor_in : div_q;
    shifted  = {src_rem, src_quo[DIV_BITS-1]};
    diff     = shifted - {1'b0, src_div};
    fits     = ~diff[DIV_BITS];
    next_rem = fits ? diff[DIV_BITS-1:0] : shifted[DIV_BITS-1:0];
    next_quo = {src_quo[DIV_BITS-2:0], fits};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt       <= '0;
      busy_out  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (start_in) begin
        rem_q    <= next_rem;
        quo_q    <= next_quo;
        div_q    <= divisor_in;
        cnt      <= CNT_W'(DIV_BITS - 1);
        busy_out <= 1'b1;
      end else if (busy_out) begin
        rem_q <= next_rem;
        quo_q <= next_quo;
        cnt   <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy_out  <= 1'b0;
          valid_out <= 1'b1;
        end
      end
    end
  end

  assign quotient_out  = quo_q;
  assign remainder_out = rem_q;

endmodule

// File: rtl/center_of_mass.sv
// Per-frame centroid: accumulates mask-true pixel coordinates, and on an
// end-of-frame strobe divides the sums by the pixel count into registered x/y.
module center_of_mass
  import com_pkg::*;
#(
  parameter int H_BITS   = 11,
  parameter int V_BITS   = 10,
  parameter int DIV_BITS = DIV_BITS_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [H_BITS-1:0] x_in,
  input  logic [V_BITS-1:0] y_in,
  input  logic              valid_in,
  input  logic              tabulate_in,
  output logic [H_BITS-1:0] x_out,
  output logic [V_BITS-1:0] y_out,
  output logic              valid_out
);

  state_t              state;
  logic                start;
  logic [DIV_BITS-1:0] sum_x, sum_y, count;
  logic [DIV_BITS-1:0] next_sum_x, next_sum_y, next_count;
  logic [DIV_BITS-1:0] op_x, op_y, op_count;
  logic [DIV_BITS-1:0] quo_x, quo_y, rem_x, rem_y;
  logic                done_x, done_y, busy_x, busy_y;
  logic                accept;
  logic                unused;

  always_comb begin
    next_sum_x = sum_x;
    next_sum_y = sum_y;
    next_count = count;
    if (valid_in) begin
      next_sum_x = sum_x + DIV_BITS'(x_in);
      next_sum_y = sum_y + DIV_BITS'(y_in);
      next_count = count + DIV_BITS'(1);
    end
  end

  // The tabulate-cycle pixel belongs to the closing frame, hence next_* here.
  assign accept = tabulate_in && (state == IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      start     <= 1'b0;
      sum_x     <= '0;
      sum_y     <= '0;
      count     <= '0;
      x_out     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      start     <= 1'b0;
      valid_out <= 1'b0;
      if (accept) begin
        sum_x <= '0;
        sum_y <= '0;
        count <= '0;
      end else begin
        sum_x <= next_sum_x;
        sum_y <= next_sum_y;
        count <= next_count;
      end
      case (state)
        IDLE: begin
          if (accept && (next_count != '0)) begin
            state <= DIVIDING;
            start <= 1'b1;
          end
        end
        DIVIDING: begin
          // Stay busy through the pulse cycle so a coincident tabulate is dropped.
          if (valid_out) begin
            state <= IDLE;
          end else if (done_x) begin
            x_out     <= quo_x[H_BITS-1:0];
            y_out     <= quo_y[V_BITS-1:0];
            valid_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: operand registers carry no reset; they are only consumed by a
  // divider start that always follows a load, so their reset value is moot.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      op_x     <= next_sum_x;
      op_y     <= next_sum_y;
      op_count <= next_count;
    end
  end

  divider #(.DIV_BITS(DIV_BITS)) u_div_x (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start),
    .dividend_in  (op_x),
    .divisor_in   (op_count),
    .quotient_out (quo_x),
    .remainder_out(rem_x),
    .valid_out    (done_x),
    .busy_out     (busy_x)
  );

  divider #(.DIV_BITS(DIV_BITS)) u_div_y (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start),
    .dividend_in  (op_y),
    .divisor_in   (op_count),
    .quotient_out (quo_y),
    .remainder_out(rem_y),
    .valid_out    (done_y),
    .busy_out     (busy_y)
  );

  assign unused = ^{rem_x, rem_y, busy_x, busy_y, done_y,
                    quo_x[DIV_BITS-1:H_BITS], quo_y[DIV_BITS-1:V_BITS]};

endmodule

// File: tb/tb_center_of_mass.sv
// Bench for center_of_mass: directed frames plus random frames, every cycle
// checked against a frame-level arithmetic model of sums, counts and latency.
module tb_center_of_mass;
  import com_pkg::*;

  localparam int H_BITS = 11;
  localparam int V_BITS = 10;
  localparam int DB     = 32;
  localparam int LAT    = DB + 2;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [H_BITS-1:0] x_in;
  logic [V_BITS-1:0] y_in;
  logic              valid_in;
  logic              tabulate_in;
  logic [H_BITS-1:0] x_out;
  logic [V_BITS-1:0] y_out;
  logic              valid_out;

  always #5 clk_in = ~clk_in;

  center_of_mass #(.H_BITS(H_BITS), .V_BITS(V_BITS), .DIV_BITS(DB)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .x_in       (x_in),
    .y_in       (y_in),
    .valid_in   (valid_in),
    .tabulate_in(tabulate_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .valid_out  (valid_out)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  longint busy_end = -1;
  longint pulse_at = -1;
  longint m_sx = 0, m_sy = 0, m_cnt = 0;
  longint exp_x = 0, exp_y = 0, cur_x = 0, cur_y = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // One pixel-clock cycle: drive, update the frame model at the edge, check.
  task automatic step(input int x, input int y, input bit v, input bit tab, input bit rst);
    rst_in      = rst;
    x_in        = x[H_BITS-1:0];
    y_in        = y[V_BITS-1:0];
    valid_in    = v;
    tabulate_in = tab;
    @(posedge clk_in);
    if (rst) begin
      m_sx = 0; m_sy = 0; m_cnt = 0;
      busy_end = -1; pulse_at = -1;
      cur_x = 0; cur_y = 0;
    end else begin
      if (v) begin
        m_sx += x; m_sy += y; m_cnt++;
      end
      if (tab && cyc > busy_end) begin
        if (m_cnt > 0) begin
          exp_x    = m_sx / m_cnt;
          exp_y    = m_sy / m_cnt;
          pulse_at = cyc + LAT;
          busy_end = cyc + LAT;
        end
        m_sx = 0; m_sy = 0; m_cnt = 0;
      end
    end
    cyc++;
    @(negedge clk_in);
    if (cyc == pulse_at) begin
      cur_x = exp_x % (1 << H_BITS);
      cur_y = exp_y % (1 << V_BITS);
    end
    check("valid_out", 64'(valid_out), 64'(cyc == pulse_at));
    check("x_out", 64'(x_out), 64'(cur_x));
    check("y_out", 64'(y_out), 64'(cur_y));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tab_only();
    step(0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_in = 1'b1; x_in = '0; y_in = '0; valid_in = 1'b0; tabulate_in = 1'b0;

    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    check("reset_valid", 64'(valid_out), 64'd0);
    check("reset_x", 64'(x_out), 64'd0);
    idle(3);

    // Single pixel
    step(100, 50, 1'b1, 1'b0, 1'b0);
    tab_only();
    idle(40);
    check("single_x", 64'(x_out), 64'd100);
    check("single_y", 64'(y_out), 64'd50);

    // Three pixels, floored averages
    step(10, 20, 1'b1, 1'b0, 1'b0);
    step(11, 20, 1'b1, 1'b0, 1'b0);
    step(13, 21, 1'b1, 1'b0, 1'b0);
    tab_only();
    idle(40);
    check("three_x", 64'(x_out), 64'd11);
    check("three_y", 64'(y_out), 64'd20);

    // Empty frame: no pulse, outputs hold
    tab_only();
    idle(40);
    check("empty_x", 64'(x_out), 64'd11);
    check("empty_y", 64'(y_out), 64'd20);

    // Subsampled active frame, closing pixel carried in the tabulate cycle
    for (int yy = 0; yy < V_ACTIVE; yy += 8)
      for (int xx = 7; xx < H_ACTIVE; xx += 8)
        step(xx, yy, 1'b1, 1'b0, 1'b0);
    step(H_ACTIVE - 1, V_ACTIVE - 1, 1'b1, 1'b1, 1'b0);
    idle(40);

    // Maximum coordinates, large sums
    for (int i = 0; i < 2000; i++) step(2047, 1023, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b1, 1'b1, 1'b0);
    idle(40);
    check("max_x", 64'(x_out), 64'd2045);
    check("max_y", 64'(y_out), 64'd1022);

    // Tabulate while dividing is ignored; its pixel merges into the next frame
    step(30, 40, 1'b1, 1'b0, 1'b0);
    tab_only();
    idle(8);
    step(200, 200, 1'b1, 1'b0, 1'b0);
    tab_only();
    idle(40);
    check("overlap_x", 64'(x_out), 64'd30);
    tab_only();
    idle(40);
    check("merged_x", 64'(x_out), 64'd200);
    check("merged_y", 64'(y_out), 64'd200);

    // Tabulate coincident with the result pulse is ignored
    step(5, 5, 1'b1, 1'b0, 1'b0);
    tab_only();
    idle(LAT - 1);
    step(9, 9, 1'b1, 1'b1, 1'b0);
    idle(3);
    tab_only();
    idle(40);
    check("pulse_tab_x", 64'(x_out), 64'd9);

    // Reset mid-division aborts the result
    step(1, 1, 1'b1, 1'b0, 1'b0);
    tab_only();
    idle(5);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    idle(40);
    check("abort_x", 64'(x_out), 64'd0);
    step(7, 9, 1'b1, 1'b0, 1'b0);
    tab_only();
    idle(40);
    check("after_rst_x", 64'(x_out), 64'd7);
    check("after_rst_y", 64'(y_out), 64'd9);

    // Random frames with stray tabulates and rare resets
    for (int f = 0; f < 40; f++) begin
      int len;
      len = int'($urandom_range(1, 80));
      for (int i = 0; i < len; i++)
        step(int'($urandom_range(0, H_ACTIVE - 1)), int'($urandom_range(0, V_ACTIVE - 1)),
             1'($urandom % 2), ($urandom % 30) == 0, ($urandom % 400) == 0);
      step(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
           1'($urandom % 2), 1'b1, 1'b0);
      idle(int'($urandom_range(0, 45)));
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
